// File: rtl/alu_pkg.sv
// Shared types for the RV32I ALU op decoder: ALU op encoding, operand selects,
// opcode constants and the decoded bundle carried to execute.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_t;

    typedef enum logic [1:0] {
        A_RS1  = 2'b00,
        A_PC   = 2'b01,
        A_ZERO = 2'b10
    } a_sel_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef struct packed {
        alu_op_t     op;
        a_sel_t      a_sel;
        logic        b_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        is_branch;
        logic        illegal;
        logic [31:0] pc;
    } dec_bundle_t;

endpackage

// File: rtl/alu_dec_core.sv
// Combinational RV32I decode of one instruction word into a dec_bundle_t.
// Unused source indices are zeroed; illegal words collapse to a neutral ADD bundle.
module alu_dec_core
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output dec_bundle_t dec
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] i_imm, s_imm, b_imm, u_imm;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign i_imm  = {{20{instr[31]}}, instr[31:20]};
    assign s_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign b_imm  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign u_imm  = {instr[31:12], 12'b0};

    always_comb begin
        dec           = '0;
        dec.op        = ALU_ADD;
        dec.a_sel     = A_RS1;
        dec.pc        = pc;
        dec.rs1       = instr[19:15];
        dec.rs2       = instr[24:20];
        dec.rd        = instr[11:7];

        case (opcode)
            OPC_OP: begin
                dec.op      = alu_op_t'({instr[30], funct3});
                dec.rd_we   = 1'b1;
                dec.illegal = !((funct7 == 7'b0000000) ||
                                (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                dec.b_sel = 1'b1;
                dec.imm   = i_imm;
                dec.rs2   = '0;
                dec.rd_we = 1'b1;
                if (funct3 == 3'b101) begin
                    dec.op      = alu_op_t'({instr[30], 3'b101});
                    dec.illegal = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
                end else begin
                    dec.op      = alu_op_t'({1'b0, funct3});
                    dec.illegal = (funct3 == 3'b001) && (funct7 != 7'b0000000);
                end
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.a_sel = (opcode == OPC_LUI) ? A_ZERO : A_PC;
                dec.b_sel = 1'b1;
                dec.imm   = u_imm;
                dec.rs1   = '0;
                dec.rs2   = '0;
                dec.rd_we = 1'b1;
            end
            OPC_BRANCH: begin
                dec.imm       = b_imm;
                dec.rd        = '0;
                dec.is_branch = 1'b1;
                case (funct3[2:1])
                    2'b00:   dec.op = ALU_SUB;
                    2'b10:   dec.op = ALU_SLT;
                    2'b11:   dec.op = ALU_SLTU;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.b_sel = 1'b1;
                dec.imm   = i_imm;
                dec.rs2   = '0;
                dec.rd_we = 1'b1;
            end
            OPC_STORE: begin
                dec.b_sel = 1'b1;
                dec.imm   = s_imm;
                dec.rd    = '0;
            end
            default: dec.illegal = 1'b1;
        endcase

        if (instr[1:0] != 2'b11)
            dec.illegal = 1'b1;
        if (dec.rd == 5'd0)
            dec.rd_we = 1'b0;

        if (dec.illegal) begin
            dec.op        = ALU_ADD;
            dec.a_sel     = A_RS1;
            dec.b_sel     = 1'b0;
            dec.imm       = '0;
            dec.rd_we     = 1'b0;
            dec.is_branch = 1'b0;
        end
    end

endmodule

// File: rtl/alu_op_decoder.sv
// One-stage registered RV32I -> ALU op decoder with valid/ready on both sides.
// Define ALU_DEC_SKID_EN for a 1-entry skid buffer and a registered in_ready.
module alu_op_decoder
    import alu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_alu_op,
    output logic [1:0]  out_a_sel,
    output logic        out_b_sel,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic        out_rd_we,
    output logic        out_is_branch,
    output logic [31:0] out_pc,
    output logic        out_illegal
);

    localparam dec_bundle_t RST_BUNDLE = '{
        op: ALU_ADD, a_sel: A_RS1, b_sel: 1'b0, imm: '0,
        rs1: '0, rs2: '0, rd: '0, rd_we: 1'b0, is_branch: 1'b0,
        illegal: 1'b0, pc: RESET_PC
    };

    dec_bundle_t dec;
    dec_bundle_t out_q;
    logic        accept;
    logic        out_free;

    alu_dec_core u_core (
        .instr (in_instr),
        .pc    (in_pc),
        .dec   (dec)
    );

    assign accept   = in_valid && in_ready;
    assign out_free = !out_valid || out_ready;

`ifdef ALU_DEC_SKID_EN
    dec_bundle_t skid_q;
    logic        skid_valid;

    assign in_ready = !skid_valid;

    // A free output slot drains the skid first; accept is impossible while it is full.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_q      <= RST_BUNDLE;
            skid_valid <= 1'b0;
            skid_q     <= RST_BUNDLE;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_q      <= skid_q;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_q     <= dec;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end
`else
    assign in_ready = out_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q     <= RST_BUNDLE;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_q     <= dec;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

    assign out_alu_op    = out_q.op;
    assign out_a_sel     = out_q.a_sel;
    assign out_b_sel     = out_q.b_sel;
    assign out_imm       = out_q.imm;
    assign out_rs1       = out_q.rs1;
    assign out_rs2       = out_q.rs2;
    assign out_rd        = out_q.rd;
    assign out_rd_we     = out_q.rd_we;
    assign out_is_branch = out_q.is_branch;
    assign out_pc        = out_q.pc;
    assign out_illegal   = out_q.illegal;

endmodule
